// File: rtl/mem_io_responder.sv
// Memory-side responder: byte RAM, MMIO decode, tx FIFO toward the UART,
// rx pop strobe and optional cycle counter (enabled by IO_CYCLE_CNT_EN).
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                bus enable; low freezes CPU-side state
//   cpu_a/cpu_wr/cpu_dout CPU byte bus request
//   cpu_din               registered read data (1-cycle latency)
//   io_buffer_full        registered tx FIFO nearly-full flag
//   tx_data/tx_valid/tx_ready  tx FIFO head toward the UART
//   rx_data/rx_valid/rx_ready  rx byte from the UART, rx_ready = pop
//   program_stop          sticky, set by a write to 0x30004
module mem_io_responder #(
   parameter int RAM_ADDR_W    = 17,
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int FULL_MARGIN   = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] cpu_a,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        program_stop
);

   localparam int DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int PW    = TX_DEPTH_LOG2 + 1;

   logic [7:0] ram [0:(1<<RAM_ADDR_W)-1];
   logic [7:0] fifo [0:DEPTH-1];

   logic [RAM_ADDR_W-1:0] ram_addr;
   logic                  is_io, io_data, io_cnt, io_ctl;
   logic                  rd_en, wr_en;
   logic [7:0]            ram_q, io_q, io_byte, cnt_byte, push_byte;
   logic                  sel_ram;
   logic [PW-1:0]         wptr, rptr, count, count_nxt, free_nxt;
   logic                  push, push_ok, pop, full;
   logic                  unused_bits;

   assign unused_bits = ^cpu_a[31:18];

   assign ram_addr = cpu_a[RAM_ADDR_W-1:0];
   assign is_io    = cpu_a[17:16] == 2'b11;
   assign io_data  = is_io && cpu_a[15:0] == 16'h0000;
   assign io_cnt   = is_io && cpu_a[15:2] == 14'h0001;
   assign io_ctl   = io_cnt && cpu_a[1:0] == 2'b00;
   assign rd_en    = rdy_in && !cpu_wr;
   assign wr_en    = rdy_in && cpu_wr;

   // Pop the UART in the same cycle as the read so back-to-back reads
   // never see the same byte twice.
   assign rx_ready = !rst_in && rd_en && io_data && rx_valid;

`ifdef IO_CYCLE_CNT_EN
   logic [31:0] cyc_cnt, cyc_snap;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cyc_cnt  <= '0;
         cyc_snap <= '0;
      end else if (rdy_in) begin
         cyc_cnt <= cyc_cnt + 32'd1;
         if (rd_en && io_ctl)
            cyc_snap <= cyc_cnt;
      end
   end

   // Byte 0 comes from the live counter; upper bytes from the snapshot
   // taken by that same read, so a 4-byte read sequence is coherent.
   always_comb begin
      cnt_byte = 8'h00;
      unique case (cpu_a[1:0])
         2'd0: cnt_byte = cyc_cnt[7:0];
         2'd1: cnt_byte = cyc_snap[15:8];
         2'd2: cnt_byte = cyc_snap[23:16];
         2'd3: cnt_byte = cyc_snap[31:24];
      endcase
   end
`else
   assign cnt_byte = 8'h00;
`endif

   always_comb begin
      io_byte = 8'h00;
      if (io_data && rx_valid)
         io_byte = rx_data;
      else if (io_cnt)
         io_byte = cnt_byte;
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in && !rst_in && !is_io) begin
         if (cpu_wr)
            ram[ram_addr] <= cpu_dout;
         else
            ram_q <= ram[ram_addr];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         io_q    <= 8'h00;
         sel_ram <= 1'b0;
      end else if (rd_en) begin
         io_q    <= io_byte;
         sel_ram <= !is_io;
      end
   end

   assign cpu_din = sel_ram ? ram_q : io_q;

   always_ff @(posedge clk_in) begin
      if (rst_in)
         program_stop <= 1'b0;
      else if (wr_en && io_ctl)
         program_stop <= 1'b1;
   end

   // tx FIFO; the stop write pushes 0x00, which data writes never do.
   assign push      = wr_en && ((io_data && cpu_dout != 8'h00) || io_ctl);
   assign push_byte = io_data ? cpu_dout : 8'h00;
   assign count     = wptr - rptr;
   assign full      = count == PW'(DEPTH);
   assign push_ok   = push && !full;
   assign tx_valid  = wptr != rptr;
   assign pop       = tx_valid && tx_ready;
   assign tx_data   = fifo[rptr[TX_DEPTH_LOG2-1:0]];
   assign count_nxt = count + PW'(push_ok) - PW'(pop);
   assign free_nxt  = PW'(DEPTH) - count_nxt;

   always_ff @(posedge clk_in) begin
      if (!rst_in && push_ok)
         fifo[wptr[TX_DEPTH_LOG2-1:0]] <= push_byte;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wptr           <= '0;
         rptr           <= '0;
         io_buffer_full <= 1'b0;
      end else begin
         if (push_ok)
            wptr <= wptr + PW'(1);
         if (pop)
            rptr <= rptr + PW'(1);
         io_buffer_full <= free_nxt <= PW'(FULL_MARGIN);
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: a queue-based reference model
// predicts every output; a negedge monitor compares.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, cpu_wr, tx_ready, rx_valid;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout, rx_data;
   logic [7:0]  cpu_din, tx_data;
   logic        io_buffer_full, tx_valid, rx_ready, program_stop;

   mem_io_responder dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .program_stop(program_stop)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] din;
      bit         din_ok;
      bit         full;
      bit         tv;
      logic [7:0] td;
      bit         stop;
      bit         rxr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;

   // reference model state
   logic [7:0]  ram_m [int];
   logic [7:0]  txm[$];
   logic [7:0]  m_din;
   bit          m_din_ok, m_full, m_stop;
   int unsigned m_cnt, m_snap;
   bit          g_txr, g_rxv;
   logic [7:0]  g_rxd;

   task automatic check(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.din_ok) check("cpu_din", cpu_din, e.din);
         check("io_buffer_full", {7'd0, io_buffer_full}, {7'd0, e.full});
         check("tx_valid", {7'd0, tx_valid}, {7'd0, e.tv});
         if (e.tv) check("tx_data", tx_data, e.td);
         check("program_stop", {7'd0, program_stop}, {7'd0, e.stop});
         check("rx_ready", {7'd0, rx_ready}, {7'd0, e.rxr});
      end
   end

   task automatic cyc(input bit rst, input bit rdy, input logic [31:0] a,
                      input bit wr, input logic [7:0] d, input bit txr,
                      input bit rxv, input logic [7:0] rxd);
      exp_t       e;
      logic [17:0] la;
      bit         io, want;
      logic [7:0] pb;
      int         k;
      @(posedge clk_in);
      #1;
      rst_in = rst; rdy_in = rdy; cpu_a = a; cpu_wr = wr;
      cpu_dout = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
      la = a[17:0];
      io = a[17:16] == 2'b11;
      e.din = m_din; e.din_ok = m_din_ok; e.full = m_full;
      e.tv = txm.size() != 0;
      e.td = e.tv ? txm[0] : 8'h00;
      e.stop = m_stop;
      e.rxr = !rst && rdy && !wr && la == 18'h30000 && rxv;
      sb.push_back(e);
      if (rst) begin
         txm.delete();
         m_din = 0; m_din_ok = 1; m_stop = 0; m_full = 0;
         m_cnt = 0; m_snap = 0;
      end else begin
         want = 0; pb = 0;
         if (rdy) begin
            if (wr) begin
               if (!io) ram_m[int'(a[16:0])] = d;
               else if (la == 18'h30000 && d != 0) begin
                  want = 1; pb = d;
               end else if (la == 18'h30004) begin
                  want = 1; pb = 0; m_stop = 1;
               end
            end else begin
               m_din_ok = 1;
               if (!io) begin
                  if (ram_m.exists(int'(a[16:0])))
                     m_din = ram_m[int'(a[16:0])];
                  else
                     m_din_ok = 0;
               end else if (la == 18'h30000) begin
                  m_din = rxv ? rxd : 8'h00;
               end else if (la[17:2] == 16'hC001) begin
                  k = int'(la[1:0]);
`ifdef IO_CYCLE_CNT_EN
                  if (k == 0) begin
                     m_din = 8'(m_cnt & 255);
                     m_snap = m_cnt;
                  end else
                     m_din = 8'((m_snap >> (8 * k)) & 255);
`else
                  m_din = 8'h00 + 8'(k * 0);
`endif
               end else
                  m_din = 0;
            end
            m_cnt = m_cnt + 1;
         end
         want = want && txm.size() < 16;
         if (txr && txm.size() > 0) void'(txm.pop_front());
         if (want) txm.push_back(pb);
         m_full = (16 - txm.size()) <= 2;
      end
   endtask

   task automatic wr_(input logic [31:0] a, input logic [7:0] d);
      cyc(0, 1, a, 1, d, g_txr, g_rxv, g_rxd);
   endtask

   task automatic rd_(input logic [31:0] a);
      cyc(0, 1, a, 0, 8'h00, g_txr, g_rxv, g_rxd);
   endtask

   task automatic idle(input int n);
      repeat (n) rd_(32'h0003_0008);
   endtask

   task automatic rst_(input int n);
      repeat (n) cyc(1, 1, 32'h0003_0008, 0, 8'h00, g_txr, 0, 8'h00);
   endtask

   logic [31:0] pool [8];

   initial begin
      logic [31:0] a;
      int          kind;
      rst_in = 1; rdy_in = 0; cpu_a = 0; cpu_wr = 0; cpu_dout = 0;
      tx_ready = 0; rx_valid = 0; rx_data = 0;
      m_din = 0; m_din_ok = 0; m_stop = 0; m_full = 0;
      m_cnt = 0; m_snap = 0;
      g_txr = 1; g_rxv = 0; g_rxd = 0;
      rst_(3);

      // RAM round trip
      wr_(32'h0000_0100, 8'hA5);
      rd_(32'h0000_0100);
      idle(2);

      // UART output: 0x00 data write is ignored
      wr_(32'h0003_0000, 8'h41);
      wr_(32'h0003_0000, 8'h00);
      idle(3);

      // Backpressure
      g_txr = 0;
      repeat (14) wr_(32'h0003_0000, 8'h55);
      idle(2);
      g_txr = 1;
      idle(20);

      // Input pop
      g_rxv = 1; g_rxd = 8'h7E;
      rd_(32'h0003_0000);
      g_rxv = 0;
      rd_(32'h0003_0000);
      idle(2);

      // Cycle counter with 20 stalled cycles interleaved
      rst_(2);
      for (int i = 0; i < 320; i++)
         cyc(0, (i % 16) != 5, 32'h0003_0008, 0, 8'h00, 1, 0, 8'h00);
      for (int i = 4; i < 8; i++) rd_(32'h0003_0000 + 32'(i));
      idle(2);

      // Stop, then reset
      wr_(32'h0003_0004, 8'h99);
      idle(3);
      wr_(32'h0003_0004, 8'h11);
      idle(2);
      rst_(1);
      idle(2);

      // Randomised traffic
      for (int i = 0; i < 8; i++)
         pool[i] = {$urandom_range(0, 16383), 1'b0, 17'($urandom)};
      for (int i = 0; i < 8; i++) wr_(pool[i], 8'($urandom));
      for (int i = 0; i < 2500; i++) begin
         kind = $urandom_range(0, 9);
         if (kind < 4)
            a = pool[$urandom_range(0, 7)];
         else if (kind < 7)
            a = {14'($urandom), 18'h30000};
         else if (kind < 8)
            a = {14'($urandom), 16'hC001, 2'($urandom)};
         else
            a = {14'($urandom), 2'b11, 16'($urandom_range(8, 65535))};
         if (i % 500 == 499)
            cyc(1, 1, a, 0, 8'h00, 1, 0, 8'h00);
         else
            cyc(0, $urandom_range(0, 9) != 0, a, $urandom_range(0, 2) == 0,
                ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                8'($urandom));
      end
      idle(20);
      @(negedge clk_in);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
